// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, the error-response word and the word-index width helper.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_NOP_WORD    = 32'h0000_0013;
  localparam int          IMEM_DEPTH_WORDS = 256;
  localparam int          IMEM_IDX_W       = $clog2(IMEM_DEPTH_WORDS);

  // Word-index width for a store of the given depth; never narrower than one bit.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch-side bus of the instruction-memory responder: request, response and load channels.
// master = fetch unit / boot loader, slave = responder.
interface imem_if;
  import imem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  modport master (
    output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction store: one synchronous read port and one write port.
// A read and write to the same word on one edge returns the old word.
module imem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_reg;

  // Non-blocking update of both mem and rdata_reg gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/imem_responder.sv
// Responder end of the instruction-fetch bus: accepts one word fetch, waits WAIT_STATES
// cycles, then returns the word or an error. Optional counters enabled by IMEM_STATS_EN.
module imem_responder
  import imem_pkg::*;
#(
  parameter int          DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  imem_if.slave       bus
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] stat_rsp_cnt,
  output logic [31:0] stat_err_cnt
`endif
);

  localparam int IDX_W = idx_w(DEPTH_WORDS);

  state_t           state;
  logic [3:0]       cnt_reg;
  logic [IDX_W-1:0] addr_reg;
  logic             err_reg;
  logic             req_ready_reg;
  logic             rsp_valid_reg;
  logic             rsp_err_reg;

  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic             ld_ok;
  logic             enter_resp;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_err;
  logic             rd_en;
  logic [31:0]      rd_data;

  assign req_idx = bus.req_addr[IDX_W+1:2];
  assign req_err = (bus.req_addr[1:0] != 2'b00) ||
                   (bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign ld_ok   = bus.ld_en && (bus.ld_addr[1:0] == 2'b00) &&
                   (bus.ld_addr[31:2] < 30'(DEPTH_WORDS));

  // The store is read on the RESP-entry edge; with no wait states that is the accept edge.
  always_comb begin
    enter_resp = 1'b0;
    rd_idx     = addr_reg;
    rd_err     = err_reg;
    if (state == IDLE) begin
      enter_resp = bus.req_valid && (WAIT_STATES == 0);
      rd_idx     = req_idx;
      rd_err     = req_err;
    end else if (state == WAIT) begin
      enter_resp = (cnt_reg == 4'd0);
    end
    rd_en = enter_resp && !rd_err;
  end

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ld_ok),
    .waddr (bus.ld_addr[IDX_W+1:2]),
    .wdata (bus.ld_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      err_reg       <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_reg      <= req_idx;
            err_reg       <= req_err;
            req_ready_reg <= 1'b0;
            if (WAIT_STATES == 0) begin
              state         <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_err_reg   <= req_err;
            end else begin
              cnt_reg <= 4'(WAIT_STATES - 1);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state         <= RESP;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= err_reg;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            req_ready_reg <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_err   = rsp_err_reg;
  // Error responses never read the store, so the held read word is masked by NOP_WORD.
  assign bus.rsp_data  = !rsp_valid_reg ? 32'h0 : (rsp_err_reg ? NOP_WORD : rd_data);

`ifdef IMEM_STATS_EN
  logic [31:0] stat_rsp_reg;
  logic [31:0] stat_err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rsp_reg <= 32'd0;
      stat_err_reg <= 32'd0;
    end else if (rsp_valid_reg && bus.rsp_ready) begin
      stat_rsp_reg <= stat_rsp_reg + 32'd1;
      if (rsp_err_reg) begin
        stat_err_reg <= stat_err_reg + 32'd1;
      end
    end
  end

  assign stat_rsp_cnt = stat_rsp_reg;
  assign stat_err_cnt = stat_err_reg;
`endif

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder end of the instruction-fetch interface. Accepts word-fetch requests from the fetch unit over a valid/ready request channel.
- Reads an internal instruction store after a parameterised number of wait states, then returns the word over a valid/ready response channel.
- Includes a side load port so a bench or boot loader can write program words into the store.
- Sits between the fetch stage and program storage, replacing a zero-latency combinational instruction ROM.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words in the store. Power of two, minimum 4.
- WAIT_STATES, 1: extra cycles between request acceptance and response. Range 0..15.
- NOP_WORD, 32'h0000_0013: data returned alongside an error response (RV32I addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address of the requested instruction.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  fetch unit accepts the response.
- rsp_data  out  32  instruction word.
- rsp_err  out  1  request was misaligned or out of range.
- ld_en  in  1  write strobe for the load port.
- ld_addr  in  32  byte address for the load port.
- ld_data  in  32  word to store.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, wait counter=0.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0.
  - Store contents are NOT reset.
  - Asserting rst mid-transaction aborts it; no response is issued for the aborted request.
- States:
  - IDLE: req_ready=1. On req_valid, capture req_addr and evaluate the error condition.
    - If WAIT_STATES=0, go to RESP.
    - Otherwise load the counter with WAIT_STATES-1 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; at counter 0 go to RESP.
  - RESP: req_ready=0, rsp_valid=1. rsp_data and rsp_err are stable until the handshake. On rsp_ready, return to IDLE.
- Timing:
  - The response becomes valid exactly WAIT_STATES+1 cycles after the accept edge.
  - One request may be outstanding; no pipelining.
  - Back-to-back throughput is one request per WAIT_STATES+2 cycles.
  - Response data and error are registered on entry to RESP.
- Errors:
  - Condition: req_addr[1:0]!=0, or req_addr[31:2] >= DEPTH_WORDS.
  - Error response: rsp_err=1, rsp_data=NOP_WORD, and the store is not read.
  - Otherwise rsp_err=0 and rsp_data=store[req_addr[31:2]].
- Load port:
  - Active in any state. Writes store[ld_addr[31:2]] on the clk edge when ld_en=1.
  - Misaligned or out-of-range loads are silently dropped.
  - Same-cycle collision (a load to the word being captured on the RESP-entry edge): read-before-write, so the response carries the old word.
- In RESP, the request side ignores req_valid; the fetch unit holds its request until it sees req_ready.

Optional Feature:
- Macro: IMEM_STATS_EN.
- When defined, two extra outputs are added:
  - stat_rsp_cnt [31:0]: counts completed response handshakes.
  - stat_err_cnt [31:0]: counts handshakes that had rsp_err=1.
- Both counters reset to 0 on rst and wrap modulo 2^32.
- When undefined, neither port nor counters exist, and behaviour is otherwise identical.

Decomposition:
- Shared package imem_pkg holds:
  - state enum {IDLE, WAIT, RESP};
  - the NOP_WORD constant;
  - the word-index helper width, log2(DEPTH_WORDS).
- One natural sub-module, imem_array: storage with one synchronous read port and one write port, read-before-write. The FSM, counter, error check and handshake stay in imem_responder.

Test Plan:
- Latency: load 0xDEADBEEF at addr 0x10, WAIT_STATES=1; request 0x10 accepted at cycle T -> rsp_valid=1 at T+2, rsp_data=0xDEADBEEF, rsp_err=0.
- Misaligned request: request 0x12 -> rsp_err=1, rsp_data=0x00000013.
- Out of range: request 0x400 with DEPTH_WORDS=256 -> rsp_err=1, rsp_data=0x00000013.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data and rsp_err stay constant and req_ready=0; release -> IDLE next cycle with req_ready=1.
- Collision: load 0x11111111 to addr 0x20, then request 0x20; on the RESP-entry edge, load 0x22222222 to 0x20 -> response is 0x11111111; a following request returns 0x22222222.
- Reset mid-WAIT (WAIT_STATES=3): assert rst during WAIT -> rsp_valid is never asserted and req_ready=1 after release. With IMEM_STATS_EN defined: 3 good requests plus 1 bad -> stat_rsp_cnt=4, stat_err_cnt=1.
